// File: rtl/eth_tx_arbiter.sv
// Two-source byte-stream arbiter feeding a MAC TX FIFO; frame-atomic grants, round-robin on ties.
// Latency: grant registered one clock after request in IDLE; data/ready then pass through with zero added latency.
// Backpressure: i_eth_wready routed straight to the granted source; idle-stall watchdog aborts hung frames.
// Optional: define ETH_ARB_FRAME_COUNT_EN to add per-source completed-frame counters.
module eth_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IFG_CYCLES     = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_s0_data,
  input  logic        i_s0_valid,
  input  logic        i_s0_last,
  output logic        o_s0_ready,
  input  logic [7:0]  i_s1_data,
  input  logic        i_s1_valid,
  input  logic        i_s1_last,
  output logic        o_s1_ready,
  output logic [7:0]  o_eth_wdata,
  output logic        o_eth_wvalid,
  input  logic        i_eth_wready,
  output logic [1:0]  o_grant,
  output logic        o_abort
`ifdef ETH_ARB_FRAME_COUNT_EN
  ,
  output logic [15:0] o_s0_frames,
  output logic [15:0] o_s1_frames
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);
  localparam bit          NO_GAP   = (IFG_CYCLES == 0);

  state_t      state, state_nxt;
  logic        owner;       // 0 = source 0, 1 = source 1
  logic        ptr;         // last-served source
  logic [15:0] wd_cnt;
  logic [15:0] gap_cnt;

  logic        src_valid, src_last, xfer;
  logic [7:0]  src_data;
  logic        grant_ld, grant_sel, frame_end, frame_done;
  logic        wd_clr, wd_inc, gap_inc;

  assign src_valid = owner ? i_s1_valid : i_s0_valid;
  assign src_last  = owner ? i_s1_last  : i_s0_last;
  assign src_data  = owner ? i_s1_data  : i_s0_data;
  assign xfer      = (state == BUSY) & src_valid & i_eth_wready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and all arbiter outputs; outputs are quiet outside BUSY
  always_comb begin
    state_nxt    = state;
    grant_ld     = 1'b0;
    grant_sel    = owner;
    frame_end    = 1'b0;
    frame_done   = 1'b0;
    wd_clr       = 1'b0;
    wd_inc       = 1'b0;
    gap_inc      = 1'b0;
    o_eth_wvalid = 1'b0;
    o_eth_wdata  = 8'h00;
    o_s0_ready   = 1'b0;
    o_s1_ready   = 1'b0;
    o_grant      = 2'b00;
    o_abort      = 1'b0;
    case (state)
      IDLE: begin
        if (i_s0_valid | i_s1_valid) begin
          grant_ld  = 1'b1;
          // On a tie the source that was not served last wins
          grant_sel = (i_s0_valid & i_s1_valid) ? ~ptr : i_s1_valid;
          wd_clr    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        o_eth_wvalid = src_valid;
        o_eth_wdata  = src_data;
        o_s0_ready   = ~owner & i_eth_wready;
        o_s1_ready   = owner & i_eth_wready;
        o_grant      = owner ? 2'b10 : 2'b01;
        if (xfer) begin
          // A transfer always beats a timeout landing on the same cycle
          wd_clr = 1'b1;
          if (src_last) begin
            frame_end  = 1'b1;
            frame_done = 1'b1;
          end
        end else if (!src_valid) begin
          // Only source starvation counts; MAC backpressure is not a stall
          if (wd_cnt >= WD_LAST) begin
            o_abort   = 1'b1;
            frame_end = 1'b1;
          end else begin
            wd_inc = 1'b1;
          end
        end
        if (frame_end) state_nxt = NO_GAP ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt >= GAP_LAST) state_nxt = IDLE;
        else                     gap_inc   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, round-robin pointer, watchdog and inter-frame gap counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner   <= 1'b0;
      ptr     <= 1'b1;
      wd_cnt  <= 16'h0000;
      gap_cnt <= 16'h0000;
    end else begin
      if (grant_ld)    owner <= grant_sel;
      if (frame_end)   ptr   <= owner;
      if (wd_clr)      wd_cnt <= 16'h0000;
      else if (wd_inc) wd_cnt <= wd_cnt + 16'h0001;
      if (frame_end)    gap_cnt <= 16'h0000;
      else if (gap_inc) gap_cnt <= gap_cnt + 16'h0001;
    end
  end

`ifdef ETH_ARB_FRAME_COUNT_EN
  // Completed-frame counters; aborted frames never reach frame_done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_s0_frames <= 16'h0000;
      o_s1_frames <= 16'h0000;
    end else if (frame_done) begin
      if (owner) o_s1_frames <= o_s1_frames + 16'h0001;
      else       o_s0_frames <= o_s0_frames + 16'h0001;
    end
  end
`endif

endmodule
